layer_out_serializer: RTL and testbench
=======================================

Name: layer_out_serializer

Overview:
- Sits between two fully-connected layers.
- Captures the parallel activation outputs of the NUM_NEURON neurons of layer N (one lane per neuron, each with its own out/outvalid pair).
- Replays them as a contiguous serial stream of myinput/myinputValid beats for every neuron of layer N+1.
- The downstream neuron's weight read address advances once per beat, so exactly NUM_NEURON beats per frame is mandatory.

Parameters:
- NUM_NEURON, 10, neurons in the producing layer; equals numWeight of the consuming layer.
- DATA_WIDTH, 16, activation word width; equals dataWidth of both layers.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- neuron_out  in  NUM_NEURON*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- neuron_valid  in  NUM_NEURON  per-lane single-cycle outvalid pulse.
- ser_data  out  DATA_WIDTH  serial activation to next layer (myinput).
- ser_valid  out  1  serial beat valid (myinputValid).
- busy  out  1  high from first captured lane until the last serial beat.
- overrun  out  1  sticky error: lane result lost; cleared only by reset.

Behaviour:
- Reset (async assert, sync-style deassert not required): ser_data=0, ser_valid=0, busy=0, overrun=0, state=IDLE, capture flags cleared, beat counter 0. Reset mid-frame discards all captured data.
- Capture: when neuron_valid[k]=1, lane k word is registered into bank slot k and flag k is set.
  - Lanes may arrive skewed, in any order, and several in the same cycle.
- States:
  - IDLE: no flags set. Any valid -> COLLECT, except all lanes in one cycle -> SHIFT directly.
  - COLLECT: waiting for remaining flags. Last missing flag set -> SHIFT on next edge.
  - SHIFT: beat counter 0..NUM_NEURON-1.
    - Each cycle: ser_valid=1, ser_data=slot[counter], lane 0 first.
    - After beat NUM_NEURON-1: flags cleared, -> IDLE.
- Latency: final lane valid in cycle t gives first beat in cycle t+1 and last beat in cycle t+NUM_NEURON.
  - ser_valid never gaps within a frame.
  - ser_data is held at its last value when ser_valid=0.
- busy = (state != IDLE).
- Overrun cases:
  - A valid on lane k whose flag is already set (COLLECT) sets overrun. The new word is dropped and the old word is kept.
  - In base build, any valid during SHIFT sets overrun and is dropped.
- Edge case: a valid arriving in the cycle of the last SHIFT beat counts as arriving during SHIFT.
- No arithmetic; data passes bit-exact. The counter width is $clog2(NUM_NEURON) and wraps only via the explicit return to IDLE.

Optional Feature:
- Macro: LAYER_SER_DBUF_EN.
- Defined:
  - Adds a shadow bank with its own flags. Valids during SHIFT are captured into the shadow bank instead of being dropped.
  - At end of SHIFT the shadow bank is swapped in:
    - Shadow complete -> next frame starts in the very next cycle (back-to-back, ser_valid stays high).
    - Shadow partially filled -> COLLECT.
    - Shadow empty -> IDLE.
  - overrun is set only on a repeat valid to an already-flagged shadow slot.
- Undefined: single bank, behaviour as above.

Decomposition:
- Shared package nn_pkg:
  - ser_state_t enum {IDLE, COLLECT, SHIFT}.
  - Default NN_DATA_WIDTH=16.
  - Helper function for lane slicing.
- One natural sub-module, ser_capture_bank:
  - Holds NUM_NEURON words plus flags, with capture, clear and all_full/any_full outputs.
  - Instantiated once (twice under LAYER_SER_DBUF_EN).

Test Plan:
- Aligned frame: NUM_NEURON=10, all valid in cycle 5, lane k = 16'h0100+k -> ser_valid cycles 6..15, data 0x0100..0x0109 in order, busy 5..15.
- Skewed lanes: lane 9 at cycle 2, lanes 0-8 at cycle 7 -> busy from 2, first beat cycle 8, ten contiguous beats, overrun=0.
- Duplicate lane: lane 3 = 0xAAAA at cycle 2, lane 3 = 0x5555 at cycle 4, rest at cycle 6 -> overrun=1 sticky, beat 3 = 0xAAAA.
- Valid during SHIFT, base build -> overrun=1, no extra beats, returns to IDLE after 10 beats.
- Valid during SHIFT with LAYER_SER_DBUF_EN -> 20 contiguous beats (frame 2 starts cycle after frame 1 last beat), overrun=0.
- rst_n low at beat 4 -> ser_valid=0 and busy=0 immediately (async). A later full frame serializes correctly from lane 0.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state type, widths and lane helper for the layer serializer
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SHIFT
  } ser_state_t;

  // Bit offset of lane k inside a flattened bus of w-bit lane words.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/ser_capture_bank.sv
// rtl/ser_capture_bank.sv - one bank of per-lane activation slots with occupancy flags
module ser_capture_bank
  import nn_pkg::*;
#(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = NN_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_NEURON-1:0]            cap,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] cap_data,
  input  logic                             clr,
  output logic [NUM_NEURON*DATA_WIDTH-1:0] words,
  output logic [NUM_NEURON-1:0]            flags,
  output logic                             all_full,
  output logic                             any_full
);

  // Occupancy includes this cycle's captures so the owner can act on the same edge.
  assign all_full = &(flags | cap);
  assign any_full = |(flags | cap);

  // Flags set on capture and drop together once the frame has been replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (clr) begin
      flags <= '0;
    end else begin
      flags <= flags | cap;
    end
  end

  // Slot k takes lane k's word only on a capture; the caller masks repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
    end else begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        if (cap[k]) begin
          words[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] <= cap_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/layer_out_serializer.sv
// rtl/layer_out_serializer.sv - parallel neuron outputs to serial frame; LAYER_SER_DBUF_EN adds a shadow bank
module layer_out_serializer
  import nn_pkg::*;
#(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = NN_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURON-1:0]            neuron_valid,
  output logic [DATA_WIDTH-1:0]            ser_data,
  output logic                             ser_valid,
  output logic                             busy,
  output logic                             overrun
);

  localparam int CW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_NEURON - 1);

  ser_state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] cur_word;
  logic overrun_q;
  logic shifting;
  logic last_beat;
  logic [NUM_NEURON*DATA_WIDTH-1:0] words;
  logic all_full;
  logic any_full;
  logic lost;

  assign shifting  = (state_q == SHIFT);
  assign last_beat = shifting && (cnt_q == LAST_BEAT);

`ifdef LAYER_SER_DBUF_EN
  logic act_q;
  logic fill_sel;
  logic [1:0][NUM_NEURON-1:0] cap_b;
  logic [1:0][NUM_NEURON-1:0] flags_b;
  logic [1:0][NUM_NEURON*DATA_WIDTH-1:0] words_b;
  logic [1:0] clr_b;
  logic [1:0] all_b;
  logic [1:0] any_b;

  // Arrivals fill the active bank while waiting and the shadow bank while replaying.
  assign fill_sel = shifting ? ~act_q : act_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign cap_b[b] = (fill_sel == 1'(b)) ? (neuron_valid & ~flags_b[b]) : '0;
    assign clr_b[b] = last_beat && (act_q == 1'(b));
    ser_capture_bank #(
      .NUM_NEURON(NUM_NEURON),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (cap_b[b]),
      .cap_data (neuron_out),
      .clr      (clr_b[b]),
      .words    (words_b[b]),
      .flags    (flags_b[b]),
      .all_full (all_b[b]),
      .any_full (any_b[b])
    );
  end

  assign words    = words_b[act_q];
  assign all_full = all_b[fill_sel];
  assign any_full = any_b[fill_sel];
  assign lost     = |(neuron_valid & flags_b[fill_sel]);

  // Bank roles swap as the last beat of a frame goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
    end else if (last_beat) begin
      act_q <= ~act_q;
    end
  end
`else
  logic [NUM_NEURON-1:0] cap;
  logic [NUM_NEURON-1:0] flags;

  // Single bank: nothing may be captured while its contents are being replayed.
  assign cap  = shifting ? '0 : (neuron_valid & ~flags);
  assign lost = shifting ? |neuron_valid : |(neuron_valid & flags);

  ser_capture_bank #(
    .NUM_NEURON(NUM_NEURON),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (cap),
    .cap_data (neuron_out),
    .clr      (last_beat),
    .words    (words),
    .flags    (flags),
    .all_full (all_full),
    .any_full (any_full)
  );
`endif

  assign cur_word = words[lane_lsb(int'(cnt_q), DATA_WIDTH) +: DATA_WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state from the fill level of the filling bank; outputs follow the state.
  always_comb begin
    state_d   = state_q;
    ser_valid = 1'b0;
    busy      = 1'b0;
    ser_data  = hold_q;
    case (state_q)
      IDLE, COLLECT: begin
        state_d = all_full ? SHIFT : (any_full ? COLLECT : IDLE);
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = cur_word;
        if (last_beat) begin
`ifdef LAYER_SER_DBUF_EN
          state_d = all_full ? SHIFT : (any_full ? COLLECT : IDLE);
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy = (state_q != IDLE);
  end

  // Beat counter walks lane 0 upward and restarts for a back-to-back frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!shifting || last_beat) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Last beat is kept so ser_data holds steady between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (shifting) begin
      hold_q <= cur_word;
    end
  end

  // Sticky loss indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (lost) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb/tb_layer_out_serializer.sv - randomized model-checked bench for layer_out_serializer
module tb_layer_out_serializer;
  import nn_pkg::*;

  localparam int N = 10;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*W-1:0] neuron_out;
  logic [N-1:0] neuron_valid;
  logic [W-1:0] ser_data;
  logic ser_valid;
  logic busy;
  logic overrun;

  layer_out_serializer #(
    .NUM_NEURON(N),
    .DATA_WIDTH(W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .neuron_out   (neuron_out),
    .neuron_valid (neuron_valid),
    .ser_data     (ser_data),
    .ser_valid    (ser_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: the frame being gathered, and a queue of beats still owed downstream.
  logic [W-1:0] m_word [N];
  bit m_flag [N];
  logic [W-1:0] sched [$];
  bit m_ovr;
  logic [W-1:0] m_last;

  int b_cyc [$];
  logic [W-1:0] b_dat [$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_flag[i] = 1'b0;
      m_word[i] = '0;
    end
    sched.delete();
    m_ovr = 1'b0;
    m_last = '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model, then feed this cycle's inputs into the model.
  always @(negedge clk) begin : cmp
    bit sh;
    bit anyf;
    bit full;
    if (chk_en && rst_n) begin
      sh = (sched.size() > 0);
      if (sh) m_last = sched.pop_front();
      anyf = 1'b0;
      for (int i = 0; i < N; i++) anyf |= m_flag[i];
      check("ser_valid", ser_valid, sh);
      check("ser_data", ser_data, m_last);
      check("busy", busy, sh || anyf);
      check("overrun", overrun, m_ovr);
      if (ser_valid) begin
        b_cyc.push_back(cyc);
        b_dat.push_back(ser_data);
      end
      for (int k = 0; k < N; k++) begin
        if (neuron_valid[k]) begin
`ifdef LAYER_SER_DBUF_EN
          if (m_flag[k]) m_ovr = 1'b1;
          else begin
            m_flag[k] = 1'b1;
            m_word[k] = neuron_out[k*W +: W];
          end
`else
          if (sh || m_flag[k]) m_ovr = 1'b1;
          else begin
            m_flag[k] = 1'b1;
            m_word[k] = neuron_out[k*W +: W];
          end
`endif
        end
      end
      full = 1'b1;
      for (int i = 0; i < N; i++) full &= m_flag[i];
      if (full && sched.size() == 0) begin
        for (int i = 0; i < N; i++) begin
          sched.push_back(m_word[i]);
          m_flag[i] = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d);
    neuron_valid = v;
    neuron_out = d;
    @(posedge clk);
    #1;
    neuron_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [N*W-1:0] ramp(input logic [W-1:0] base);
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = base + W'(k);
    return d;
  endfunction

  function automatic logic [N*W-1:0] rnd_words();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
    return d;
  endfunction

  initial begin
    logic [N-1:0] v;
    logic [N*W-1:0] d;
    int t;
    neuron_valid = '0;
    neuron_out = '0;
    model_reset();
    rst_n = 1'b0;
    idle(3);
    check("rst ser_valid", ser_valid, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);
    check("rst ser_data", ser_data, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Aligned frame.
    b_cyc.delete(); b_dat.delete();
    t = cyc;
    drive('1, ramp(16'h0100));
    idle(12);
    check("aligned beats", b_cyc.size(), 10);
    check("aligned first cyc", b_cyc[0], t + 1);
    check("aligned last cyc", b_cyc[9], t + 10);
    check("aligned beat0", b_dat[0], 16'h0100);
    check("aligned beat9", b_dat[9], 16'h0109);

    // Skewed lanes: lane 9 first, the rest five cycles later.
    b_cyc.delete(); b_dat.delete();
    d = ramp(16'h2000);
    drive(10'b10_0000_0000, d);
    check("skew busy early", busy, 1);
    idle(4);
    t = cyc;
    drive(10'b01_1111_1111, d);
    idle(12);
    check("skew beats", b_cyc.size(), 10);
    check("skew first cyc", b_cyc[0], t + 1);
    check("skew lane9", b_dat[9], 16'h2009);
    check("skew overrun", overrun, 0);

    // Duplicate lane keeps the first word.
    b_cyc.delete(); b_dat.delete();
    d = ramp(16'h3000);
    d[3*W +: W] = 16'hAAAA;
    drive(10'b00_0000_1000, d);
    idle(1);
    d[3*W +: W] = 16'h5555;
    drive(10'b00_0000_1000, d);
    idle(1);
    drive(10'b11_1111_0111, d);
    idle(12);
    check("dup overrun", overrun, 1);
    check("dup beat3", b_dat[3], 16'hAAAA);
    do_reset();

    // Valid arriving while a frame is replayed.
    b_cyc.delete(); b_dat.delete();
    drive('1, ramp(16'h4000));
    idle(3);
    drive('1, ramp(16'h5000));
    idle(20);
`ifdef LAYER_SER_DBUF_EN
    check("dbuf beats", b_cyc.size(), 20);
    check("dbuf contiguous", b_cyc[10], b_cyc[9] + 1);
    check("dbuf beat10", b_dat[10], 16'h5000);
    check("dbuf overrun", overrun, 0);
`else
    check("shift beats", b_cyc.size(), 10);
    check("shift overrun", overrun, 1);
    check("shift idle", busy, 0);
`endif
    do_reset();

    // Asynchronous reset in the middle of beat 4.
    b_cyc.delete(); b_dat.delete();
    drive('1, ramp(16'h6000));
    idle(4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async ser_valid", ser_valid, 0);
    check("async busy", busy, 0);
    check("async ser_data", ser_data, 0);
    idle(2);
    rst_n = 1'b1;
    b_cyc.delete(); b_dat.delete();
    drive('1, ramp(16'h7000));
    idle(12);
    check("post-rst beats", b_cyc.size(), 10);
    check("post-rst beat0", b_dat[0], 16'h7000);

    // Randomized traffic, including completions that land on the last beat.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        v = '0;
        case ($urandom_range(0, 9))
          0, 1: for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 3) == 0);
          2: for (int k = 0; k < N; k++) v[k] = ~m_flag[k];
          3: if (r > 5) v = '1;
          default: v = '0;
        endcase
        drive(v, rnd_words());
      end
      idle(25);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
